// File: rtl/alk_qreg.sv
// Q register slice of the ALK: load / shift-left / shift-right / hold on each clock,
// plus cascade serial bits and a step counter for multiply/divide micro-loops.
module alk_qreg #(
   parameter int WIDTH = 8,
   parameter int STEPS = 8,
   parameter int CNTW  = 4
) (
   input  logic             clk_h,
   input  logic             reset_h,
   input  logic             q_noshf_h,
   input  logic             q_shl_l,
   input  logic             q_shr_l,
   input  logic             q_ld_h,
   input  logic [WIDTH-1:0] d_h,
   input  logic             shl_in_h,
   input  logic             shr_in_h,
   input  logic             step_start_h,
   output logic [WIDTH-1:0] q_h,
   output logic             q_msb_out_h,
   output logic             q_lsb_out_h,
   output logic [CNTW-1:0]  step_cnt_h,
   output logic             step_done_h,
   output logic             q_err_h
);

   logic             shl, shr;
   logic             illegal, legal_shift, bad_ctl;
   logic [WIDTH-1:0] q_next;

   always_comb begin
      shl         = ~q_shl_l;
      shr         = ~q_shr_l;
      illegal     = shl & shr;
      legal_shift = shl ^ shr;
      // Decoder disagreement: noshf claims no shift but a shift line is active,
      // or noshf is low yet nothing shifts. Both are flagged but a single shift still executes.
      bad_ctl     = illegal
                  | ( q_noshf_h & legal_shift)
                  | (~q_noshf_h & ~shl & ~shr);

      q_next = q_h;
      if (illegal)
         q_next = q_h;
      else if (shl)
         q_next = {q_h[WIDTH-2:0], shl_in_h};
      else if (shr)
         q_next = {shr_in_h, q_h[WIDTH-1:1]};
      else if (q_noshf_h && q_ld_h)
         q_next = d_h;
   end

   always_ff @(posedge clk_h) begin
      if (reset_h) begin
         q_h         <= '0;
         step_cnt_h  <= '0;
         step_done_h <= 1'b1;
         q_err_h     <= 1'b0;
      end else begin
         q_h <= q_next;
         if (bad_ctl)
            q_err_h <= 1'b1;
         // A start on the same edge as a shift reloads and does not count that shift.
         if (step_start_h) begin
            step_cnt_h  <= CNTW'(STEPS);
            step_done_h <= 1'b0;
         end else if (legal_shift && step_cnt_h != '0) begin
            step_cnt_h <= step_cnt_h - 1'b1;
            if (step_cnt_h == CNTW'(1))
               step_done_h <= 1'b1;
         end
      end
   end

   assign q_msb_out_h = q_h[WIDTH-1];
   assign q_lsb_out_h = q_h[0];

endmodule

// File: tb/tb_alk_qreg.sv
// Directed bench for alk_qreg: behavioural model checked every cycle plus hand-computed expectations.
module tb_alk_qreg;

   logic       clk_h = 1'b0;
   logic       reset_h, q_noshf_h, q_shl_l, q_shr_l, q_ld_h;
   logic [7:0] d_h;
   logic       shl_in_h, shr_in_h, step_start_h;
   logic [7:0] q_h;
   logic       q_msb_out_h, q_lsb_out_h, step_done_h, q_err_h;
   logic [3:0] step_cnt_h;

   int n_checks = 0;
   int n_fail   = 0;

   alk_qreg #(.WIDTH(8), .STEPS(8), .CNTW(4)) dut (
      .clk_h(clk_h), .reset_h(reset_h), .q_noshf_h(q_noshf_h), .q_shl_l(q_shl_l),
      .q_shr_l(q_shr_l), .q_ld_h(q_ld_h), .d_h(d_h), .shl_in_h(shl_in_h),
      .shr_in_h(shr_in_h), .step_start_h(step_start_h), .q_h(q_h),
      .q_msb_out_h(q_msb_out_h), .q_lsb_out_h(q_lsb_out_h), .step_cnt_h(step_cnt_h),
      .step_done_h(step_done_h), .q_err_h(q_err_h)
   );

   always #5 clk_h = ~clk_h;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: Q as an integer, shifts as multiply/divide, counter as a plain integer.
   int mq, mcnt, nshift;
   bit mdone, merr, mvalid = 0, bad;

   always @(posedge clk_h) begin
      if (reset_h) begin
         mq = 0; mcnt = 0; mdone = 1; merr = 0; mvalid = 1;
      end else if (mvalid) begin
         nshift = (q_shl_l ? 0 : 1) + (q_shr_l ? 0 : 1);
         bad = (nshift == 2) || (q_noshf_h && nshift == 1) || (!q_noshf_h && nshift == 0);
         if (nshift == 1) begin
            if (!q_shl_l) mq = (mq * 2) % 256 + int'(shl_in_h);
            else          mq = mq / 2 + 128 * int'(shr_in_h);
         end else if (nshift == 0 && q_noshf_h && q_ld_h)
            mq = int'(d_h);
         if (bad) merr = 1;
         if (step_start_h) begin
            mcnt = 8; mdone = 0;
         end else if (nshift == 1 && mcnt > 0) begin
            mcnt = mcnt - 1;
            if (mcnt == 0) mdone = 1;
         end
      end
   end

   always @(negedge clk_h) begin
      if (mvalid) begin
         chk("model_q",    32'(q_h),         32'(mq));
         chk("model_msb",  32'(q_msb_out_h), 32'((mq >> 7) & 1));
         chk("model_lsb",  32'(q_lsb_out_h), 32'(mq & 1));
         chk("model_cnt",  32'(step_cnt_h),  32'(mcnt));
         chk("model_done", 32'(step_done_h), 32'(mdone));
         chk("model_err",  32'(q_err_h),     32'(merr));
      end
   end

   task automatic drive(input bit rst, input bit noshf, input bit shl_l, input bit shr_l,
                        input bit ld, input logic [7:0] d, input bit sl_in, input bit sr_in,
                        input bit start);
      reset_h = rst; q_noshf_h = noshf; q_shl_l = shl_l; q_shr_l = shr_l; q_ld_h = ld;
      d_h = d; shl_in_h = sl_in; shr_in_h = sr_in; step_start_h = start;
      @(posedge clk_h);
      #1;
   endtask

   task automatic do_reset();             drive(1, 1, 1, 1, 0, 8'h00, 0, 0, 0); endtask
   task automatic do_idle();              drive(0, 1, 1, 1, 0, 8'h00, 0, 0, 0); endtask
   task automatic do_load(logic [7:0] d); drive(0, 1, 1, 1, 1, d,     0, 0, 0); endtask
   task automatic do_shl(bit b);          drive(0, 0, 0, 1, 0, 8'h00, b, 0, 0); endtask
   task automatic do_shr(bit b);          drive(0, 0, 1, 0, 0, 8'h00, 0, b, 0); endtask
   task automatic do_start();             drive(0, 1, 1, 1, 0, 8'h00, 0, 0, 1); endtask

   initial begin
      reset_h = 1; q_noshf_h = 1; q_shl_l = 1; q_shr_l = 1; q_ld_h = 0;
      d_h = 0; shl_in_h = 0; shr_in_h = 0; step_start_h = 0;

      // 1: reset then load
      do_reset();
      chk("rst_q", 32'(q_h), 32'h0);
      chk("rst_cnt", 32'(step_cnt_h), 32'h0);
      chk("rst_done", 32'(step_done_h), 32'h1);
      chk("rst_err", 32'(q_err_h), 32'h0);
      do_load(8'hA5);
      chk("load_q", 32'(q_h), 32'hA5);
      chk("load_done", 32'(step_done_h), 32'h1);
      chk("load_err", 32'(q_err_h), 32'h0);

      // 2: left shift
      chk("pre_shl_msb", 32'(q_msb_out_h), 32'h1);
      do_shl(1);
      chk("shl_q", 32'(q_h), 32'h4B);
      chk("shl_msb", 32'(q_msb_out_h), 32'h0);

      // 3: right shift
      do_load(8'hA5);
      do_shr(0);
      chk("shr_q", 32'(q_h), 32'h52);
      chk("shr_lsb", 32'(q_lsb_out_h), 32'h0);

      // 4: iteration count, then a non-wrapping 9th shift
      do_start();
      chk("start_cnt", 32'(step_cnt_h), 32'h8);
      chk("start_done", 32'(step_done_h), 32'h0);
      for (int i = 1; i <= 8; i++) begin
         do_shr(0);
         chk("iter_cnt", 32'(step_cnt_h), 32'(8 - i));
         chk("iter_done", 32'(step_done_h), (i == 8) ? 32'h1 : 32'h0);
      end
      do_shr(1);
      chk("wrap_cnt", 32'(step_cnt_h), 32'h0);
      chk("wrap_done", 32'(step_done_h), 32'h1);
      chk("wrap_q", 32'(q_h), 32'h80);

      // 5: illegal control, sticky error
      do_load(8'h3C);
      drive(0, 0, 0, 0, 0, 8'h00, 1, 1, 0);
      chk("ill_q", 32'(q_h), 32'h3C);
      chk("ill_err", 32'(q_err_h), 32'h1);
      do_shl(0);
      do_load(8'h11);
      chk("ill_sticky", 32'(q_err_h), 32'h1);
      do_reset();
      chk("ill_clr", 32'(q_err_h), 32'h0);

      // start coincident with a shift: shift happens, count reloads
      do_load(8'h81);
      drive(0, 0, 0, 1, 0, 8'h00, 0, 0, 1);
      chk("startshl_q", 32'(q_h), 32'h02);
      chk("startshl_cnt", 32'(step_cnt_h), 32'h8);

      // inconsistent: noshf=1 with a shift line -> shift wins, error flagged
      do_reset();
      do_load(8'hF0);
      drive(0, 1, 1, 0, 1, 8'h00, 0, 1, 0);
      chk("inc1_q", 32'(q_h), 32'hF8);
      chk("inc1_err", 32'(q_err_h), 32'h1);

      // inconsistent: noshf=0 with no shift -> hold, load ignored, error flagged
      do_reset();
      do_load(8'h0F);
      drive(0, 0, 1, 1, 1, 8'h55, 0, 0, 0);
      chk("inc2_q", 32'(q_h), 32'h0F);
      chk("inc2_err", 32'(q_err_h), 32'h1);

      // 6: reset mid-iteration
      do_reset();
      do_load(8'h5A);
      do_start();
      do_shl(1); do_shl(0); do_shr(1);
      chk("mid_cnt", 32'(step_cnt_h), 32'h5);
      drive(1, 0, 0, 1, 0, 8'h00, 1, 0, 0);
      chk("mid_rst_q", 32'(q_h), 32'h0);
      chk("mid_rst_cnt", 32'(step_cnt_h), 32'h0);
      chk("mid_rst_done", 32'(step_done_h), 32'h1);
      do_idle();
      @(negedge clk_h);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
